// File: rtl/data_mem_pkg.sv
// Shared types and constants for the synchronous data memory: FSM states,
// init pattern encodings and the wait-state ceiling.
package data_mem_pkg;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int PAT_ZERO     = 0;
   localparam int PAT_INDEX    = 1;
   localparam int WAIT_CYC_MAX = 15;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage with a byte-lane write port and a registered read port.
// A read that coincides with a write returns the merged (post-write) word.
module data_mem_array #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     q
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int BE_W  = DATA_W/8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write-first per lane: disabled lanes keep and return the stored byte.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         if (re) begin
            q[8*i +: 8] <= (we && be[i]) ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/data_mem_sync.sv
// Single-port word-addressed data memory with byte-lane writes, a valid/ready
// request/response handshake, configurable wait states and self-initialisation.
module data_mem_sync
   import data_mem_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 8,
   parameter int WAIT_CYC     = 1,
   parameter int INIT_PATTERN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  init_done
);

   localparam int         BE_W      = DATA_W/8;
   localparam int         WAIT_EFF  = (WAIT_CYC > WAIT_CYC_MAX) ? WAIT_CYC_MAX : WAIT_CYC;
   localparam logic [3:0] WAIT_LOAD = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;

   state_t              state;
   logic [ADDR_W-1:0]   init_cnt;
   logic [3:0]          wait_cnt;
   logic                rsp_loaded;

   logic                accept;
   logic                in_init;
   logic                arr_we;
   logic [ADDR_W-1:0]   arr_addr;
   logic [DATA_W-1:0]   arr_wdata;
   logic [BE_W-1:0]     arr_be;
   logic [DATA_W-1:0]   arr_q;
   logic [DATA_W-1:0]   pat_word;

   assign accept    = req_valid && req_ready;
   assign in_init   = (state == ST_INIT);
   assign pat_word  = (INIT_PATTERN == PAT_INDEX) ? DATA_W'(init_cnt) : '0;

   assign arr_we    = in_init || (accept && req_write);
   assign arr_addr  = in_init ? init_cnt : req_addr;
   assign arr_wdata = in_init ? pat_word : req_wdata;
   assign arr_be    = in_init ? '1 : req_be;

   // The array output register is the response register; it only loads on an
   // accepted request, so it holds across handshakes. Before the first
   // request after reset it is masked to zero.
   assign rsp_rdata = rsp_loaded ? arr_q : '0;

   data_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (accept),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .be    (arr_be),
      .q     (arr_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         init_cnt   <= '0;
         wait_cnt   <= 4'd0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         init_done  <= 1'b0;
         rsp_loaded <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (&init_cnt) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  req_ready  <= 1'b0;
                  rsp_loaded <= 1'b1;
                  if (WAIT_EFF > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: three instances (WAIT_CYC=2, WAIT_CYC=0,
// and 32-bit zero-init) driven and sampled on the falling clock edge.
module tb_data_mem_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // instance a: defaults, WAIT_CYC=2
   logic        a_rst_n, a_req_valid, a_req_ready, a_req_write;
   logic [7:0]  a_req_addr;
   logic [15:0] a_req_wdata, a_rsp_rdata;
   logic [1:0]  a_req_be;
   logic        a_rsp_valid, a_rsp_ready, a_init_done;
   // instance b: WAIT_CYC=0
   logic        b_rst_n, b_req_valid, b_req_ready, b_req_write;
   logic [7:0]  b_req_addr;
   logic [15:0] b_req_wdata, b_rsp_rdata;
   logic [1:0]  b_req_be;
   logic        b_rsp_valid, b_rsp_ready, b_init_done;
   // instance c: DATA_W=32, INIT_PATTERN=0, WAIT_CYC=1
   logic        c_rst_n, c_req_valid, c_req_ready, c_req_write;
   logic [7:0]  c_req_addr;
   logic [31:0] c_req_wdata, c_rsp_rdata;
   logic [3:0]  c_req_be;
   logic        c_rsp_valid, c_rsp_ready, c_init_done;

   data_mem_sync #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(2), .INIT_PATTERN(1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .req_be(a_req_be), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .init_done(a_init_done));

   data_mem_sync #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(0), .INIT_PATTERN(1)) u_b (
      .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .req_be(b_req_be), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .init_done(b_init_done));

   data_mem_sync #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(1), .INIT_PATTERN(0)) u_c (
      .clk(clk), .rst_n(c_rst_n), .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_write(c_req_write), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
      .req_be(c_req_be), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
      .rsp_rdata(c_rsp_rdata), .init_done(c_init_done));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request on a and return at the falling edge after acceptance.
   task automatic a_send(input logic wr, input logic [7:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
      int t = 0;
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
      a_req_wdata = wd;   a_req_be = be;
      while (!a_req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!a_req_ready) check("a_accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
   endtask

   // Count falling-edge samples after acceptance until rsp_valid is seen.
   task automatic a_wait_rsp(output int lat);
      lat = 1;
      while (!a_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic a_txn(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp);
      int lat;
      a_send(wr, addr, wd, be);
      a_wait_rsp(lat);
      check({tag, "_lat"}, 64'(lat), 64'd3);
      check({tag, "_data"}, 64'(a_rsp_rdata), 64'(exp));
      a_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic c_txn(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
      int t = 0;
      int lat = 1;
      c_req_valid = 1'b1; c_req_write = wr; c_req_addr = addr;
      c_req_wdata = wd;   c_req_be = be;
      while (!c_req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!c_req_ready) check("c_accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      c_req_valid = 1'b0;
      while (!c_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd2);
      check({tag, "_data"}, 64'(c_rsp_rdata), 64'(exp));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int lat;
      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
      c_req_valid = 1'b0; c_req_write = 1'b0; c_req_addr = '0; c_req_wdata = '0; c_req_be = '0;
      a_rsp_ready = 1'b1; b_rsp_ready = 1'b1; c_rsp_ready = 1'b1;
      #2;
      a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_req_ready",   64'(a_req_ready), 64'd0);
      check("rst_rsp_valid",   64'(a_rsp_valid), 64'd0);
      check("rst_rsp_rdata",   64'(a_rsp_rdata), 64'd0);
      check("rst_init_done",   64'(a_init_done), 64'd0);
      check("rst_c_init_done", 64'(c_init_done), 64'd0);

      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
      cyc = 0;
      while (!a_init_done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("init_cycles", 64'(cyc), 64'd256);
      check("init_ready",  64'(a_req_ready), 64'd1);
      check("init_c_done", 64'(c_init_done), 64'd1);

      // read of the index-pattern word
      a_txn("read_2a", 1'b0, 8'h2A, 16'h0000, 2'b00, 16'h002A);

      // upper-lane write merges with the init word
      a_txn("wr_10",   1'b1, 8'h10, 16'hBEEF, 2'b10, 16'hBE10);
      a_txn("rd_10",   1'b0, 8'h10, 16'h0000, 2'b00, 16'hBE10);

      // zero byte-enable write leaves the word untouched
      a_txn("wr_be0",  1'b1, 8'h20, 16'hFFFF, 2'b00, 16'h0020);
      a_txn("rd_20",   1'b0, 8'h20, 16'h0000, 2'b00, 16'h0020);

      // backpressure with a second request held on the inputs
      a_rsp_ready = 1'b0;
      a_send(1'b0, 8'h2A, 16'h0000, 2'b00);
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h11;
      a_wait_rsp(lat);
      check("bp_lat", 64'(lat), 64'd3);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(a_rsp_valid), 64'd1);
         check("bp_rdata", 64'(a_rsp_rdata), 64'h002A);
         check("bp_ready", 64'(a_req_ready), 64'd0);
         @(negedge clk);
      end
      a_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_post_ready", 64'(a_req_ready), 64'd1);
      check("bp_post_valid", 64'(a_rsp_valid), 64'd0);
      check("bp_post_hold",  64'(a_rsp_rdata), 64'h002A);
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      a_wait_rsp(lat);
      check("bp_next_lat",  64'(lat), 64'd3);
      check("bp_next_data", 64'(a_rsp_rdata), 64'h0011);
      @(posedge clk);
      @(negedge clk);

      // reset during WAIT discards the response and re-initialises memory
      a_send(1'b1, 8'h05, 16'h1234, 2'b11);
      a_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(a_rsp_valid), 64'd0);
      check("mid_rst_ready", 64'(a_req_ready), 64'd0);
      check("mid_rst_done",  64'(a_init_done), 64'd0);
      check("mid_rst_rdata", 64'(a_rsp_rdata), 64'd0);
      @(negedge clk);
      a_rst_n = 1'b1;
      cyc = 0;
      while (!a_init_done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("reinit_cycles", 64'(cyc), 64'd256);
      a_txn("rd_05", 1'b0, 8'h05, 16'h0000, 2'b00, 16'h0005);

      // WAIT_CYC=0: back-to-back reads, 2-cycle period
      check("b_init_done", 64'(b_init_done), 64'd1);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'hFF;
      cyc = 0;
      while (!b_req_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("b_ready", 64'(b_req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("b_ff_valid", 64'(b_rsp_valid), 64'd1);
      check("b_ff_data",  64'(b_rsp_rdata), 64'h00FF);
      check("b_ff_ready", 64'(b_req_ready), 64'd0);
      b_req_addr = 8'h00;
      @(posedge clk);
      @(negedge clk);
      check("b_gap_valid", 64'(b_rsp_valid), 64'd0);
      check("b_gap_ready", 64'(b_req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      b_req_valid = 1'b0;
      check("b_00_valid", 64'(b_rsp_valid), 64'd1);
      check("b_00_data",  64'(b_rsp_rdata), 64'h0000);
      @(posedge clk);
      @(negedge clk);
      check("b_end_valid", 64'(b_rsp_valid), 64'd0);

      // 32-bit, zero-initialised instance
      c_txn("c_wr_03", 1'b1, 8'h03, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD);
      c_txn("c_rd_03", 1'b0, 8'h03, 32'h00000000, 4'b0000, 32'h00BB00DD);
      c_txn("c_rd_77", 1'b0, 8'h77, 32'h00000000, 4'b0000, 32'h00000000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
